// File: rtl/iob_axistream_packer.sv
// iob_axistream_packer
//   Packs an 8-bit AXI-stream into OUT_BYTES-wide little-endian words.
//   Byte k of a word sits at m_tdata[8k+7:8k]. A frame end (s_tlast) flushes
//   a partial word, and m_tkeep marks its valid bytes contiguously from bit 0.
//   Completed frames (m_tlast beats accepted by the sink) are counted in
//   frame_cnt.
//
// Ports
//   clk, arst_n          clock, asynchronous active-low reset
//   en                   enable; when low no new input bytes are accepted
//   s_tdata/s_tvalid/s_tready/s_tlast   byte stream in
//   m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast   word stream out
//   frame_cnt            frames emitted, wraps at 2^CNT_W
//
// OUT_BYTES must be >= 2.

// One byte lane: holds the accumulator byte and the output-register byte.
module iob_axistream_packer_lane (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       wr,     // store din into the accumulator (non-completing byte)
  input  logic       ld,     // word completes: load the output lane, clear accumulator
  input  logic       at,     // this lane is the current byte position
  input  logic       below,  // this lane is below the current byte position
  input  logic [7:0] din,
  output logic [7:0] tdata,
  output logic       tkeep
);

  logic [7:0] acc;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  acc <= '0;
    else if (ld)  acc <= '0;
    else if (wr)  acc <= din;
  end

  // The completing byte bypasses the accumulator and goes straight to the
  // output lane; lanes above the completing position load zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tdata <= '0;
      tkeep <= 1'b0;
    end else if (ld) begin
      tkeep <= at | below;
      tdata <= at ? din : (below ? acc : 8'h00);
    end
  end

endmodule

module iob_axistream_packer #(
  parameter int OUT_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   en,
  input  logic [7:0]             s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [8*OUT_BYTES-1:0] m_tdata,
  output logic [OUT_BYTES-1:0]   m_tkeep,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int POS_W = $clog2(OUT_BYTES);

  logic [POS_W-1:0] pos;
  logic             fire;
  logic             complete;
  logic             retire;

  // Ready only when the output register is free or draining this cycle, so a
  // completing byte always has somewhere to go.
  assign s_tready = en & (~m_tvalid | m_tready);
  assign fire     = s_tvalid & s_tready;
  assign complete = fire & (s_tlast | (pos == POS_W'(OUT_BYTES-1)));
  assign retire   = m_tvalid & m_tready;

  for (genvar k = 0; k < OUT_BYTES; k++) begin : g_lane
    iob_axistream_packer_lane u_lane (
      .clk    (clk),
      .arst_n (arst_n),
      .wr     (fire & ~complete & (pos == POS_W'(k))),
      .ld     (complete),
      .at     (pos == POS_W'(k)),
      .below  (pos > POS_W'(k)),
      .din    (s_tdata),
      .tdata  (m_tdata[8*k +: 8]),
      .tkeep  (m_tkeep[k])
    );
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)        pos <= '0;
    else if (complete)  pos <= '0;
    else if (fire)      pos <= pos + POS_W'(1);
  end

  // A word completing on the retire edge loads straight in, keeping m_tvalid high.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (complete) begin
      m_tvalid <= 1'b1;
      m_tlast  <= s_tlast;
    end else if (retire) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                 frame_cnt <= '0;
    else if (retire & m_tlast)   frame_cnt <= frame_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_iob_axistream_packer.sv
module tb_iob_axistream_packer;

  localparam int OB = 4;
  localparam int CW = 4;  // narrow counter so random traffic exercises the wrap

  logic            clk;
  logic            arst_n;
  logic            en;
  logic [7:0]      s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [8*OB-1:0] m_tdata;
  logic [OB-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [CW-1:0]   frame_cnt;

  iob_axistream_packer #(.OUT_BYTES(OB), .CNT_W(CW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .en        (en),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the word being built, plus the word the sink
  // should currently see.
  logic [7:0]      mq[$];
  logic            ev;
  logic            elast;
  logic [8*OB-1:0] ew;
  logic [OB-1:0]   ekeep;
  logic [CW-1:0]   fcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ev = 1'b0; elast = 1'b0; ew = '0; ekeep = '0; fcnt = '0;
  endtask

  // One clock: drive inputs, check ready, advance the model across the edge,
  // then check outputs on the following falling edge.
  task automatic cyc(input logic e, input logic v, input logic [7:0] d,
                     input logic l, input logic r, output logic took);
    logic exp_rdy, ret;
    en = e; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
    #1;
    exp_rdy = e & (~ev | r);
    chk("s_tready", {63'd0, s_tready}, {63'd0, exp_rdy});
    took = v & exp_rdy;
    ret  = ev & r;
    if (ret && elast) fcnt = fcnt + 1'b1;
    if (took) begin
      mq.push_back(d);
      if (l || mq.size() == OB) begin
        ew = '0;
        foreach (mq[i]) ew[8*i +: 8] = mq[i];
        ekeep = OB'((1 << mq.size()) - 1);
        elast = l;
        ev    = 1'b1;
        mq.delete();
      end else if (ret) ev = 1'b0;
    end else if (ret) ev = 1'b0;
    @(negedge clk);
    chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, ev});
    if (ev) begin
      chk("m_tdata", {32'd0, m_tdata}, {32'd0, ew});
      chk("m_tkeep", {60'd0, m_tkeep}, {60'd0, ekeep});
      chk("m_tlast", {63'd0, m_tlast}, {63'd0, elast});
    end
    chk("frame_cnt", {60'd0, frame_cnt}, {60'd0, fcnt});
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic t;
    cyc(1'b1, 1'b1, d, l, 1'b1, t);
    chk("send_taken", {63'd0, t}, 64'd1);
  endtask

  task automatic idle();
    logic t;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, t);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {63'd0, m_tvalid}, 64'd0);
    chk({tag, "_last"},  {63'd0, m_tlast},  64'd0);
    chk({tag, "_data"},  {32'd0, m_tdata},  64'd0);
    chk({tag, "_keep"},  {60'd0, m_tkeep},  64'd0);
    chk({tag, "_cnt"},   {60'd0, frame_cnt}, 64'd0);
  endtask

  initial begin
    logic t;
    int i;
    logic [8*OB-1:0] held;
    en = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    arst_n = 1'b1;
    model_reset();
    #3 arst_n = 1'b0;
    #1 chk_zero_outputs("rst");
    @(negedge clk);
    arst_n = 1'b1;

    // Full word with tlast on the top lane
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    chk("tp1_data", {32'd0, m_tdata}, 64'h44332211);
    chk("tp1_keep", {60'd0, m_tkeep}, 64'hF);
    chk("tp1_last", {63'd0, m_tlast}, 64'd1);
    idle();
    chk("tp1_cnt", {60'd0, frame_cnt}, 64'd1);

    // Partial words
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    chk("tp2_data", {32'd0, m_tdata}, 64'h00CCBBAA);
    chk("tp2_keep", {60'd0, m_tkeep}, 64'h7);
    send(8'h5A, 1);
    chk("tp2b_data", {32'd0, m_tdata}, 64'h0000005A);
    chk("tp2b_keep", {60'd0, m_tkeep}, 64'h1);
    idle();

    // Two-word frame back to back
    for (int k = 1; k <= 8; k++) begin
      send(8'(k), k == 8);
      if (k == 4) chk("tp3_w0", {32'd0, m_tdata}, 64'h04030201);
    end
    chk("tp3_w1", {32'd0, m_tdata}, 64'h08070605);
    chk("tp3_last", {63'd0, m_tlast}, 64'd1);
    idle();

    // Sink stalls for 10 cycles after the first word
    i = 0;
    for (int n = 0; n < 40 && i < 8; n++) begin
      cyc(1'b1, 1'b1, 8'(8'h10 + i), i == 7, !(n >= 4 && n < 14), t);
      if (t) i++;
      if (n == 4) held = m_tdata;
      if (n > 4 && n < 14) chk("tp4_hold", {32'd0, m_tdata}, {32'd0, held});
    end
    chk("tp4_all_sent", i, 8);
    idle(); idle();

    // Enable dropped mid-frame
    send(8'h11, 0); send(8'h22, 0);
    for (int n = 0; n < 5; n++) cyc(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, t);
    send(8'h33, 0); send(8'h44, 1);
    chk("tp5_data", {32'd0, m_tdata}, 64'h44332211);
    chk("tp5_keep", {60'd0, m_tkeep}, 64'hF);
    idle();

    // Reset mid-frame
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    s_tvalid = 1'b0;
    arst_n = 1'b0;
    #1 chk_zero_outputs("tp6_rst");
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    send(8'h99, 1);
    chk("tp6_data", {32'd0, m_tdata}, 64'h00000099);
    chk("tp6_keep", {60'd0, m_tkeep}, 64'h1);
    idle();
    chk("tp6_cnt", {60'd0, frame_cnt}, 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 8'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_axistream_packer.md
Name: iob_axistream_packer

Overview:
- Downstream neighbour of the AXI-stream byte output peripheral. Consumes its 8-bit stream (tdata/tvalid/tready/tlast) and packs consecutive bytes little-endian into OUT_BYTES-wide words.
- Emits the words on a wide AXI-stream master with tkeep and tlast, for a DMA or wide-FIFO sink.
- Partial words are flushed at frame end (tlast).
- Keeps a count of completed frames for software status.

Parameters:
- OUT_BYTES, 4: bytes per output word; must be ≥2.
- CNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- en  in  1  packer enable; when 0, no new input bytes are accepted
- s_tdata  in  8  input byte
- s_tvalid  in  1  input byte valid
- s_tready  out  1  packer can accept a byte
- s_tlast  in  1  byte is last of frame
- m_tdata  out  8*OUT_BYTES  packed word; byte k at bits [8k+7:8k]
- m_tkeep  out  OUT_BYTES  valid-byte mask, contiguous from bit 0
- m_tvalid  out  1  word valid
- m_tready  in  1  sink accepts word
- m_tlast  out  1  word closes a frame
- frame_cnt  out  CNT_W  frames emitted (m_tlast beats accepted)

Behaviour:
- Reset (arst_n=0, takes effect immediately, no clock needed):
  - m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, frame_cnt=0.
  - Byte position pos=0; accumulator cleared.
- Input acceptance:
  - s_tready = en & (~m_tvalid | m_tready). It is combinational and never depends on s_tvalid.
  - A byte is accepted on a clock edge where s_tvalid & s_tready.
- Accumulation:
  - An accepted byte is stored in accumulator lane pos.
  - If pos==OUT_BYTES-1 or s_tlast=1, the word completes. Otherwise pos increments.
- Word completion, on the same edge as the completing byte:
  - Output register loads the accumulator lanes [0..pos-1] plus the incoming byte in lane pos.
  - m_tkeep = (1<<(pos+1))-1. Unused lanes are 0.
  - m_tlast = s_tlast; m_tvalid = 1.
  - pos returns to 0 and the accumulator is cleared.
  - Latency: word visible on m_* the cycle after the completing byte is accepted.
- Output handshake:
  - While m_tvalid & ~m_tready, m_tdata, m_tkeep and m_tlast are held stable.
  - On m_tvalid & m_tready, the word is retired. m_tvalid drops the next cycle unless a new word completes on the same edge, in which case the new word loads directly.
  - Sustained throughput is 1 byte/cycle when m_tready=1.
- Backpressure:
  - Bytes are refused only when the output register is occupied and not draining.
  - The accumulator never overflows, because a completing byte is accepted only when the output register is free.
- frame_cnt increments by 1 on each accepted word with m_tlast=1. It wraps from 2^CNT_W-1 to 0.
- en deassertion:
  - Mid-frame, accumulated bytes and pos are retained.
  - A pending output word still drains.
  - Packing resumes when en returns to 1.
- Exact multiple:
  - tlast on lane OUT_BYTES-1 gives m_tkeep all ones and m_tlast=1.
  - No extra empty word is ever emitted.
- Reset mid-frame discards the partial accumulator and any pending output word.

Test Plan:
- OUT_BYTES=4, m_tready=1; send 0x11,0x22,0x33,0x44(tlast) back-to-back -> one beat m_tdata=0x44332211, m_tkeep=0xF, m_tlast=1, one cycle after 0x44 is accepted; frame_cnt=1.
- Send 0xAA,0xBB,0xCC(tlast) -> m_tdata=0x00CCBBAA, m_tkeep=0x7, m_tlast=1. Then send a single byte 0x5A(tlast) -> m_tdata=0x0000005A, m_tkeep=0x1.
- 8-byte frame 0x01..0x08, tlast on 0x08, m_tready=1 -> two beats: 0x04030201 (keep=0xF, last=0) then 0x08070605 (keep=0xF, last=1). s_tready stays 1 throughout.
- Hold m_tready=0 for 10 cycles after the first word completes -> s_tready=0 at most from the cycle m_tvalid=1; m_* stable. Release m_tready -> both words delivered intact, no byte loss or duplication.
- Deassert en after 2 bytes of a frame for 5 cycles, then resume with 2 more bytes (tlast) -> s_tready=0 while en=0; single word 0x44332211-pattern with keep=0xF.
- Assert arst_n=0 after 3 bytes of a frame, release, then send 0x99(tlast) -> outputs 0 during reset; the next word is 0x00000099, keep=0x1, and frame_cnt counts from 0.
